// File: rtl/little_mem_pkg.sv
// Shared types and constants for the two-port memory arbiter.
//   arb_state_e     : arbiter FSM states (IDLE, WAIT)
//   port_e          : requesting port select (PORT_I instruction, PORT_D data)
//   DEFAULT_TIMEOUT : default response timeout in WAIT cycles
//   rr_pick         : round-robin choice between two eligible ports
package little_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

    // When both ports are eligible, the one not granted last wins.
    function automatic port_e rr_pick(input logic elig_i, input logic elig_d, input port_e last);
        if (elig_i && elig_d) begin
            return (last == PORT_I) ? PORT_D : PORT_I;
        end else if (elig_i) begin
            return PORT_I;
        end else begin
            return PORT_D;
        end
    endfunction

endpackage

// File: rtl/mem_req_slot.sv
// Single-entry pending-request slot for one arbiter port.
//   clk, reset         : clock, asynchronous active-low reset
//   req                : one-cycle request pulse
//   req_addr/wdata/wstrb : request fields captured with the pulse
//   clear              : release the slot (response or abort delivered)
//   busy               : slot holds a request (pending or in flight)
//   addr/wdata/wstrb   : stored fields while busy, otherwise the live inputs,
//                        so a same-cycle pulse can be granted without delay
module mem_req_slot (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic        clear,
    output logic        busy,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb
);

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (clear) begin
            busy <= 1'b0;
        end else if (req && !busy) begin
            // A pulse while busy is dropped: one outstanding request per port.
            busy    <= 1'b1;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

    assign addr  = busy ? addr_q  : req_addr;
    assign wdata = busy ? wdata_q : req_wdata;
    assign wstrb = busy ? wstrb_q : req_wstrb;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-cycle-response memory.
//   clk, reset                          : clock, asynchronous active-low reset
//   i_mem_ready, i_mem_addr             : instruction read request pulse + address
//   i_mem_valid, i_mem_rdata, i_mem_err : instruction response pulse, data, abort flag
//   d_mem_ready, d_mem_addr, d_mem_wdata, d_mem_wstrb : data request pulse + fields
//   d_mem_valid, d_mem_rdata, d_mem_err : data response pulse, data, abort flag
//   mem_ready, mem_instr, mem_addr, mem_wdata, mem_wstrb : request to memory
//   mem_valid, mem_rdata                : memory response
// TIMEOUT: WAIT cycles allowed before an outstanding request is aborted.
module mem_arbiter
    import little_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_addr,
    output logic        i_mem_valid,
    output logic [31:0] i_mem_rdata,
    output logic        i_mem_err,
    input  logic        d_mem_ready,
    input  logic [31:0] d_mem_addr,
    input  logic [31:0] d_mem_wdata,
    input  logic [3:0]  d_mem_wstrb,
    output logic        d_mem_valid,
    output logic [31:0] d_mem_rdata,
    output logic        d_mem_err,
    output logic        mem_ready,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e       state;
    port_e            granted;
    port_e            last_grant;
    port_e            grant;
    logic [CNT_W-1:0] wait_cnt;

    logic        i_busy, d_busy;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [3:0]  i_wstrb, d_wstrb;
    logic        elig_i, elig_d;
    logic        timeout_hit, done;
    logic        clear_i, clear_d;

    mem_req_slot u_slot_i (
        .clk       (clk),
        .reset     (reset),
        .req       (i_mem_ready),
        .req_addr  (i_mem_addr),
        .req_wdata (32'h0),
        .req_wstrb (4'h0),
        .clear     (clear_i),
        .busy      (i_busy),
        .addr      (i_addr),
        .wdata     (i_wdata),
        .wstrb     (i_wstrb)
    );

    mem_req_slot u_slot_d (
        .clk       (clk),
        .reset     (reset),
        .req       (d_mem_ready),
        .req_addr  (d_mem_addr),
        .req_wdata (d_mem_wdata),
        .req_wstrb (d_mem_wstrb),
        .clear     (clear_d),
        .busy      (d_busy),
        .addr      (d_addr),
        .wdata     (d_wdata),
        .wstrb     (d_wstrb)
    );

    // In IDLE nothing is in flight, so a busy slot is simply pending.
    assign elig_i      = i_busy || i_mem_ready;
    assign elig_d      = d_busy || d_mem_ready;
    assign grant       = rr_pick(elig_i, elig_d, last_grant);
    // A response on the final WAIT cycle wins over the abort.
    assign timeout_hit = (state == WAIT) && !mem_valid && (wait_cnt == CNT_LAST);
    assign done        = (state == WAIT) && (mem_valid || timeout_hit);
    assign clear_i     = done && (granted == PORT_I);
    assign clear_d     = done && (granted == PORT_D);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            granted     <= PORT_I;
            last_grant  <= PORT_D;
            wait_cnt    <= '0;
            mem_ready   <= 1'b0;
            mem_instr   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            i_mem_valid <= 1'b0;
            i_mem_rdata <= '0;
            i_mem_err   <= 1'b0;
            d_mem_valid <= 1'b0;
            d_mem_rdata <= '0;
            d_mem_err   <= 1'b0;
        end else begin
            mem_ready   <= 1'b0;
            i_mem_valid <= 1'b0;
            i_mem_err   <= 1'b0;
            d_mem_valid <= 1'b0;
            d_mem_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (elig_i || elig_d) begin
                        state      <= WAIT;
                        granted    <= grant;
                        last_grant <= grant;
                        wait_cnt   <= '0;
                        mem_ready  <= 1'b1;
                        if (grant == PORT_I) begin
                            mem_instr <= 1'b1;
                            mem_addr  <= i_addr;
                            mem_wdata <= i_wdata;
                            mem_wstrb <= i_wstrb;
                        end else begin
                            mem_instr <= 1'b0;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_wstrb <= d_wstrb;
                        end
                    end
                end
                WAIT: begin
                    if (done) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                        if (granted == PORT_I) begin
                            i_mem_valid <= 1'b1;
                            i_mem_err   <= timeout_hit;
                            i_mem_rdata <= mem_valid ? mem_rdata : 32'h0;
                        end else begin
                            d_mem_valid <= 1'b1;
                            d_mem_err   <= timeout_hit;
                            d_mem_rdata <= mem_valid ? mem_rdata : 32'h0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_mem_ready = 1'b0;
    logic [31:0] i_mem_addr = '0;
    logic        i_mem_valid;
    logic [31:0] i_mem_rdata;
    logic        i_mem_err;
    logic        d_mem_ready = 1'b0;
    logic [31:0] d_mem_addr = '0;
    logic [31:0] d_mem_wdata = '0;
    logic [3:0]  d_mem_wstrb = '0;
    logic        d_mem_valid;
    logic [31:0] d_mem_rdata;
    logic        d_mem_err;
    logic        mem_ready;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_rdata = '0;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_mem_ready (i_mem_ready),
        .i_mem_addr  (i_mem_addr),
        .i_mem_valid (i_mem_valid),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_err   (i_mem_err),
        .d_mem_ready (d_mem_ready),
        .d_mem_addr  (d_mem_addr),
        .d_mem_wdata (d_mem_wdata),
        .d_mem_wstrb (d_mem_wstrb),
        .d_mem_valid (d_mem_valid),
        .d_mem_rdata (d_mem_rdata),
        .d_mem_err   (d_mem_err),
        .mem_ready   (mem_ready),
        .mem_instr   (mem_instr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (port 0 = instruction, 1 = data) ----------------
    bit          m_pend  [2];     // request held for the port (pending or in flight)
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wstrb [2];
    bit          m_busy;          // a request is outstanding at the memory
    int          m_port;
    int          m_waited;
    int          m_last;
    logic        e_mem_ready, e_instr;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    bit          e_valid [2];
    bit          e_err   [2];
    logic [31:0] e_rdata [2];

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_pend[p]  = 0;
            m_addr[p]  = '0;
            m_wdata[p] = '0;
            m_wstrb[p] = '0;
            e_valid[p] = 0;
            e_err[p]   = 0;
            e_rdata[p] = '0;
        end
        m_busy = 0; m_port = 0; m_waited = 0; m_last = 1;
        e_mem_ready = 0; e_instr = 0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
    endtask

    task automatic model_finish(input int p, input logic [31:0] data, input bit err);
        e_valid[p] = 1;
        e_err[p]   = err;
        e_rdata[p] = data;
        m_pend[p]  = 0;
        m_busy     = 0;
    endtask

    initial model_reset();

    always @(posedge clk or negedge reset) begin : model_step
        bit          req [2];
        logic [31:0] ra  [2];
        logic [31:0] rw  [2];
        logic [3:0]  rs  [2];
        bit          was_busy;
        int          g;
        if (!reset) begin
            model_reset();
        end else begin
            req[0] = i_mem_ready; ra[0] = i_mem_addr; rw[0] = '0;          rs[0] = '0;
            req[1] = d_mem_ready; ra[1] = d_mem_addr; rw[1] = d_mem_wdata; rs[1] = d_mem_wstrb;
            was_busy    = m_busy;
            e_mem_ready = 0;
            for (int p = 0; p < 2; p++) begin
                e_valid[p] = 0;
                e_err[p]   = 0;
                if (req[p] && !m_pend[p]) begin
                    m_pend[p]  = 1;
                    m_addr[p]  = ra[p];
                    m_wdata[p] = rw[p];
                    m_wstrb[p] = rs[p];
                end
            end
            if (was_busy) begin
                if (mem_valid) begin
                    model_finish(m_port, mem_rdata, 0);
                end else begin
                    m_waited++;
                    if (m_waited == int'(TO)) model_finish(m_port, 32'h0, 1);
                end
            end else if (m_pend[0] || m_pend[1]) begin
                if (m_pend[0] && m_pend[1]) g = 1 - m_last;
                else g = m_pend[0] ? 0 : 1;
                m_busy = 1; m_port = g; m_last = g; m_waited = 0;
                e_mem_ready = 1;
                e_instr = (g == 0);
                e_addr  = m_addr[g];
                e_wdata = m_wdata[g];
                e_wstrb = m_wstrb[g];
            end
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("mem_ready", 32'(mem_ready), 32'(e_mem_ready));
        chk("mem_instr", 32'(mem_instr), 32'(e_instr));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
        chk("i_mem_valid", 32'(i_mem_valid), 32'(e_valid[0]));
        chk("d_mem_valid", 32'(d_mem_valid), 32'(e_valid[1]));
        chk("i_mem_rdata", i_mem_rdata, e_rdata[0]);
        chk("d_mem_rdata", d_mem_rdata, e_rdata[1]);
        if (e_valid[0]) chk("i_mem_err", 32'(i_mem_err), 32'(e_err[0]));
        if (e_valid[1]) chk("d_mem_err", 32'(d_mem_err), 32'(e_err[1]));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        i_mem_ready = 0; d_mem_ready = 0; mem_valid = 0;
    endtask

    task automatic pulse_i(input logic [31:0] a);
        i_mem_ready = 1; i_mem_addr = a;
    endtask

    task automatic pulse_d(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        d_mem_ready = 1; d_mem_addr = a; d_mem_wdata = w; d_mem_wstrb = s;
    endtask

    task automatic respond(input logic [31:0] r);
        mem_valid = 1; mem_rdata = r;
    endtask

    initial begin
        reset = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1;
        #1;
        chk("reset mem_ready", 32'(mem_ready), 32'h0);
        chk("reset i_mem_valid", 32'(i_mem_valid), 32'h0);
        tick();

        // Single fetch
        pulse_i(32'h100); tick(); quiet(); #1;
        chk("fetch mem_ready", 32'(mem_ready), 32'h1);
        chk("fetch mem_addr", mem_addr, 32'h100);
        chk("fetch mem_instr", 32'(mem_instr), 32'h1);
        chk("fetch mem_wstrb", 32'(mem_wstrb), 32'h0);
        respond(32'h13); tick(); quiet(); #1;
        chk("fetch i_mem_valid", 32'(i_mem_valid), 32'h1);
        chk("fetch i_mem_rdata", i_mem_rdata, 32'h13);
        chk("fetch i_mem_err", 32'(i_mem_err), 32'h0);
        tick();

        // Simultaneous pulses after reset: instruction first, then data
        reset = 0; tick(); reset = 1; tick();
        pulse_i(32'h0); pulse_d(32'h200, 32'hDEADBEEF, 4'hF); tick(); quiet(); #1;
        chk("rr1 mem_instr", 32'(mem_instr), 32'h1);
        chk("rr1 mem_addr", mem_addr, 32'h0);
        respond(32'h11); tick(); quiet(); #1;
        chk("rr1 i_mem_valid", 32'(i_mem_valid), 32'h1);
        tick(); #1;
        chk("rr2 mem_ready", 32'(mem_ready), 32'h1);
        chk("rr2 mem_instr", 32'(mem_instr), 32'h0);
        chk("rr2 mem_addr", mem_addr, 32'h200);
        chk("rr2 mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("rr2 mem_wstrb", 32'(mem_wstrb), 32'hF);
        respond(32'h22); tick(); quiet(); #1;
        chk("rr2 d_mem_valid", 32'(d_mem_valid), 32'h1);
        chk("rr2 d_mem_rdata", d_mem_rdata, 32'h22);
        // Last grant was data, so the third pair goes to instruction first
        pulse_i(32'h10); pulse_d(32'h210, 32'h0, 4'h0); tick(); quiet(); #1;
        chk("rr3 mem_instr", 32'(mem_instr), 32'h1);
        chk("rr3 mem_addr", mem_addr, 32'h10);
        respond(32'h33); tick(); quiet(); tick(); #1;
        chk("rr4 mem_instr", 32'(mem_instr), 32'h0);
        chk("rr4 mem_addr", mem_addr, 32'h210);
        respond(32'h44); tick(); quiet(); tick();

        // Timeout on a data read
        pulse_d(32'h300, 32'h0, 4'h0); tick(); quiet(); #1;
        chk("to mem_ready", 32'(mem_ready), 32'h1);
        tick(); tick(); tick(); #1;
        chk("to early d_mem_valid", 32'(d_mem_valid), 32'h0);
        tick(); #1;
        chk("to d_mem_valid", 32'(d_mem_valid), 32'h1);
        chk("to d_mem_err", 32'(d_mem_err), 32'h1);
        chk("to d_mem_rdata", d_mem_rdata, 32'h0);
        tick(); respond(32'hBAD); tick(); quiet(); #1;
        chk("late d_mem_valid", 32'(d_mem_valid), 32'h0);
        chk("late i_mem_valid", 32'(i_mem_valid), 32'h0);
        chk("late mem_ready", 32'(mem_ready), 32'h0);
        tick();

        // Data pulse coinciding with an instruction response
        pulse_i(32'h400); tick(); quiet(); #1;
        chk("co mem_ready", 32'(mem_ready), 32'h1);
        respond(32'h55); pulse_d(32'h500, 32'h0, 4'h0); tick(); quiet(); #1;
        chk("co i_mem_valid", 32'(i_mem_valid), 32'h1);
        chk("co i_mem_rdata", i_mem_rdata, 32'h55);
        chk("co mem_ready idle", 32'(mem_ready), 32'h0);
        tick(); #1;
        chk("co d issue", 32'(mem_ready), 32'h1);
        chk("co d addr", mem_addr, 32'h500);
        respond(32'h66); tick(); quiet(); #1;
        chk("co d_mem_rdata", d_mem_rdata, 32'h66);
        tick();

        // Reset in the middle of WAIT
        pulse_i(32'h600); tick(); quiet(); #1;
        chk("rst mem_ready pre", 32'(mem_ready), 32'h1);
        #1 reset = 0; #1;
        chk("rst mem_ready", 32'(mem_ready), 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_instr", 32'(mem_instr), 32'h0);
        chk("rst i_mem_rdata", i_mem_rdata, 32'h0);
        chk("rst d_mem_rdata", d_mem_rdata, 32'h0);
        respond(32'h77); tick(); reset = 1; tick(); quiet(); #1;
        chk("rst no i_mem_valid", 32'(i_mem_valid), 32'h0);
        chk("rst no mem_ready", 32'(mem_ready), 32'h0);
        pulse_i(32'h700); tick(); quiet(); #1;
        chk("rst next addr", mem_addr, 32'h700);
        respond(32'h88); tick(); quiet(); #1;
        chk("rst next i_mem_rdata", i_mem_rdata, 32'h88);
        tick();

        // Randomized traffic with random response delays, timeouts and resets
        for (int c = 0; c < 3000; c++) begin
            i_mem_ready = ($urandom_range(3) == 0);
            i_mem_addr  = $urandom;
            d_mem_ready = ($urandom_range(3) == 0);
            d_mem_addr  = $urandom;
            d_mem_wdata = $urandom;
            d_mem_wstrb = ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0;
            mem_valid   = ($urandom_range(2) == 0);
            mem_rdata   = $urandom;
            reset       = ($urandom_range(499) != 0);
            tick();
        end
        quiet();
        reset = 1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: cycles allowed between a memory issue and its response before abort.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports i_mem_ready in 1, i_mem_addr in 32: instruction-port read request pulse and address.
REQ-005 SHALL have ports i_mem_valid out 1, i_mem_rdata out 32, i_mem_err out 1: instruction-port response pulse, data and abort flag.
REQ-006 SHALL have ports d_mem_ready in 1, d_mem_addr in 32, d_mem_wdata in 32, d_mem_wstrb in 4: data-port request pulse, address, write data and byte strobes (0000 = read).
REQ-007 SHALL have ports d_mem_valid out 1, d_mem_rdata out 32, d_mem_err out 1: data-port response pulse, data and abort flag.
REQ-008 SHALL have ports mem_ready out 1, mem_instr out 1, mem_addr out 32, mem_wdata out 32, mem_wstrb out 4: request to the shared memory.
REQ-009 SHALL have ports mem_valid in 1, mem_rdata in 32: single-cycle response from memory.

Function
REQ-010 SHALL treat each x_mem_ready as a one-cycle request pulse and capture its address/data/strobe into a per-port pending slot on that edge.
REQ-011 SHALL hold at most one pending request per port; a pulse on a port whose slot is pending or in flight SHALL be ignored.
REQ-012 SHALL use states IDLE and WAIT; exactly one request is in flight in WAIT.
REQ-013 SHALL, in IDLE, consider pending slots and same-cycle request pulses; when either port is eligible, the next edge SHALL assert mem_ready for exactly one cycle with the granted port's fields and move to WAIT.
REQ-014 SHALL give a request arriving during IDLE a latency of one cycle from x_mem_ready high to mem_ready high.
REQ-015 SHALL arbitrate simultaneous eligibility round-robin: grant the port not granted last; last-grant register updates on each grant.
REQ-016 SHALL drive mem_instr=1, mem_wstrb=0000, mem_wdata=0 for instruction grants, and mem_instr=0 with captured d_ fields for data grants.
REQ-017 SHALL hold mem_addr/mem_wdata/mem_wstrb/mem_instr stable throughout WAIT.
REQ-018 SHALL, on mem_valid in WAIT, register mem_rdata into the granted port's x_mem_rdata, pulse x_mem_valid for one cycle on the next edge with x_mem_err=0, clear that slot and return to IDLE.
REQ-019 SHALL count WAIT cycles; if TIMEOUT cycles elapse without mem_valid, pulse x_mem_valid with x_mem_err=1 and x_mem_rdata=0 for the granted port and return to IDLE.
REQ-020 SHALL ignore mem_valid while IDLE (late or spurious responses).
REQ-021 SHALL capture a request pulse that coincides with a response or timeout edge into its slot; it is arbitrated in the following IDLE cycle.
REQ-022 SHALL keep x_mem_rdata stable between response pulses; x_mem_err is valid only while x_mem_valid is high.

Reset
REQ-023 SHALL, while reset is low, asynchronously force: state IDLE, both slots empty, last-grant = data port, timeout counter 0, mem_ready/mem_instr/i_mem_valid/d_mem_valid/i_mem_err/d_mem_err 0, all address/data/strobe/rdata outputs 0.
REQ-024 SHALL, on reset assertion mid-transaction, drop the in-flight and pending requests with no response pulse; any later mem_valid is ignored.

Structure
REQ-025 SHALL place the state enum, the port-select enum (PORT_I, PORT_D) and the default TIMEOUT constant in shared package little_mem_pkg.
REQ-026 SHALL implement the per-port pending slot as one sub-module, mem_req_slot, instantiated twice (instruction slot with write fields tied to zero).

Verification
REQ-027 Single fetch: i_mem_ready pulse addr 0x100 in IDLE -> mem_ready next cycle with mem_addr 0x100, mem_instr 1, mem_wstrb 0000; mem_valid rdata 0x00000013 -> i_mem_valid pulse with rdata 0x00000013, err 0.
REQ-028 Simultaneous pulses after reset (i addr 0x0, d write addr 0x200 data 0xDEADBEEF strb 1111) -> instruction granted first, data second with mem_wdata 0xDEADBEEF; third simultaneous pair -> instruction first again only if last grant was data.
REQ-029 Timeout: TIMEOUT=4, d read issued, no mem_valid -> after 4 WAIT cycles d_mem_valid=1, d_mem_err=1, d_mem_rdata=0; mem_valid two cycles later produces no response.
REQ-030 Coincident events: d_mem_ready pulse on the same edge as mem_valid for an instruction request -> i_mem_valid pulses, data request issued on mem_ready one cycle after return to IDLE.
REQ-031 Reset mid-WAIT: reset low for one cycle during an instruction request -> all outputs 0 immediately, no i_mem_valid afterward, next request serviced normally.
